// File: rtl/fc_arb_pkg.sv
// Shared types and default sizing for the FC engine arbiter.
package fc_arb_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_M       = 4;
  localparam int unsigned DEF_N       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Bit width able to index 0..depth-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fc_arb_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr wins.
module fc_arb_rr_picker import fc_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IW = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               any_valid
);

  function automatic logic [IW-1:0] offset_idx(input logic [IW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IW'(sum);
  endfunction

  // Walk from the farthest offset back to rr_ptr so the nearest request lands last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req[offset_idx(rr_ptr, NUM_REQ - 1 - k)]) begin
        winner    = offset_idx(rr_ptr, NUM_REQ - 1 - k);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_engine_arbiter.sv
// Shares one FC engine among NUM_REQ requesters; a job is M beats in, N beats out.
// Optional FC_ARB_PRIO0_EN: requester 0 always wins arbitration when it is requesting.
module fc_engine_arbiter import fc_arb_pkg::*; #(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned M       = DEF_M,
  parameter int unsigned N       = DEF_N,
  localparam int unsigned IW = cnt_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [WIDTH-1:0]                rsp_data,
  output logic [IW-1:0]                   rsp_id,
  output logic                            eng_in_valid,
  input  logic                            eng_in_ready,
  output logic [WIDTH-1:0]                eng_in_data,
  input  logic                            eng_out_valid,
  output logic                            eng_out_ready,
  input  logic [WIDTH-1:0]                eng_out_data
);

  localparam int unsigned MW = cnt_width(M);
  localparam int unsigned NW = cnt_width(N);
  localparam logic [MW-1:0] IN_LAST  = MW'(M - 1);
  localparam logic [NW-1:0] OUT_LAST = NW'(N - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NUM_REQ - 1);

  arb_state_e    state, state_nx;
  logic [IW-1:0] grant_id, grant_id_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [MW-1:0] in_cnt, in_cnt_nx;
  logic [NW-1:0] out_cnt, out_cnt_nx;
  logic [IW-1:0] rr_winner, pick_id;
  logic          any_valid;
  logic          in_fire, out_fire;

  fc_arb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (rr_winner),
    .any_valid (any_valid)
  );

`ifdef FC_ARB_PRIO0_EN
  assign pick_id = req_valid[0] ? '0 : rr_winner;
`else
  assign pick_id = rr_winner;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_id_nx;
      rr_ptr   <= rr_ptr_nx;
      in_cnt   <= in_cnt_nx;
      out_cnt  <= out_cnt_nx;
    end
  end

  // Handshakes pass straight through to the owner; IDLE always costs one cycle per job.
  always_comb begin
    state_nx      = state;
    grant_id_nx   = grant_id;
    rr_ptr_nx     = rr_ptr;
    in_cnt_nx     = in_cnt;
    out_cnt_nx    = out_cnt;
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_data      = '0;
    rsp_id        = '0;
    eng_in_valid  = 1'b0;
    eng_in_data   = '0;
    eng_out_ready = 1'b0;
    in_fire       = 1'b0;
    out_fire      = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_valid) begin
          grant_id_nx = pick_id;
          state_nx    = FEED;
        end
      end

      FEED: begin
        rsp_id              = grant_id;
        eng_in_valid        = req_valid[grant_id];
        eng_in_data         = req_data[grant_id];
        req_ready[grant_id] = eng_in_ready;
        in_fire             = req_valid[grant_id] & eng_in_ready;
        if (in_fire) begin
          if (in_cnt == IN_LAST) begin
            in_cnt_nx = '0;
            state_nx  = DRAIN;
          end else begin
            in_cnt_nx = in_cnt + MW'(1);
          end
        end
      end

      DRAIN: begin
        rsp_id              = grant_id;
        rsp_valid[grant_id] = eng_out_valid;
        rsp_data            = eng_out_data;
        eng_out_ready       = rsp_ready[grant_id];
        out_fire            = eng_out_valid & rsp_ready[grant_id];
        if (out_fire) begin
          if (out_cnt == OUT_LAST) begin
            out_cnt_nx = '0;
            rr_ptr_nx  = (grant_id == ID_LAST) ? '0 : grant_id + IW'(1);
            state_nx   = IDLE;
          end else begin
            out_cnt_nx = out_cnt + NW'(1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fc_engine_arbiter.sv
// Scoreboard bench for fc_engine_arbiter with a behavioural FC engine stand-in.
module tb_fc_engine_arbiter;

  localparam int W  = 16;
  localparam int NR = 4;
  localparam int M  = 4;
  localparam int N  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR-1:0][W-1:0] req_data;
  logic [W-1:0]         rsp_data, eng_in_data, eng_out_data;
  logic [1:0]           rsp_id;
  logic                 eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;

  fc_engine_arbiter #(.WIDTH(W), .NUM_REQ(NR), .M(M), .N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .eng_in_valid  (eng_in_valid),
    .eng_in_ready  (eng_in_ready),
    .eng_in_data   (eng_in_data),
    .eng_out_valid (eng_out_valid),
    .eng_out_ready (eng_out_ready),
    .eng_out_data  (eng_out_data)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [W-1:0] data; } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [W-1:0] jobq [NR][$];
  exp_t         exp_q[$];
  logic [W-1:0] eng_ib[$];
  logic [W-1:0] eng_ob[$];
  logic [W-1:0] rq_words [NR][M];
  int           rq_cnt [NR];
  int           rsp_beats [NR];
  int           grant_log[$];
  int           grant_cyc[$];

  // Transaction-level view of who owns the engine and how far the job has got.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_in    = 0;
  int m_out   = 0;

  int p_gap = 0, p_in_rdy = 100, p_out_val = 100, p_rsp_rdy = 100;
  bit rsp_toggle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Result j of a job: fixed small integer weights, wrapped to W bits.
  function automatic logic [W-1:0] fc_out(input logic [W-1:0] x [M], input int j);
    int acc;
    acc = 0;
    for (int k = 0; k < M; k++) acc += $signed(x[k]) * (((j * M + k) % 7) - 3);
    return W'(acc);
  endfunction

  function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
`ifdef FC_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Drive requesters, engine and response back-pressure just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (!reset && jobq[r].size() > 0 && $urandom_range(99) >= p_gap) begin
        req_valid[r] = 1'b1;
        req_data[r]  = jobq[r][0];
      end else begin
        req_valid[r] = 1'b0;
        req_data[r]  = W'($urandom);
      end
      if (rsp_toggle) rsp_ready[r] = (cyc % 2) == 1;
      else            rsp_ready[r] = $urandom_range(99) < p_rsp_rdy;
    end
    eng_in_ready = !reset && ($urandom_range(99) < p_in_rdy);
    if (!reset && eng_ob.size() > 0 && $urandom_range(99) < p_out_val) begin
      eng_out_valid = 1'b1;
      eng_out_data  = eng_ob[0];
    end else begin
      eng_out_valid = 1'b0;
      eng_out_data  = W'($urandom);
    end
  end

  // Stimulus-side bookkeeping: completed input jobs queue their expected results.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      for (int r = 0; r < NR; r++) begin
        jobq[r].delete();
        rq_cnt[r] = 0;
      end
      eng_ib.delete();
      eng_ob.delete();
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && req_ready[r] && jobq[r].size() > 0) begin
          rq_words[r][rq_cnt[r]] = jobq[r].pop_front();
          rq_cnt[r]++;
          if (rq_cnt[r] == M) begin
            for (int j = 0; j < N; j++) exp_q.push_back('{id: r, data: fc_out(rq_words[r], j)});
            rq_cnt[r] = 0;
          end
        end
      end
      if (eng_in_valid && eng_in_ready) begin
        eng_ib.push_back(eng_in_data);
        if (eng_ib.size() == M) begin
          logic [W-1:0] tmp [M];
          for (int k = 0; k < M; k++) tmp[k] = eng_ib[k];
          for (int j = 0; j < N; j++) eng_ob.push_back(fc_out(tmp, j));
          eng_ib.delete();
        end
      end
      if (eng_out_valid && eng_out_ready && eng_ob.size() > 0) void'(eng_ob.pop_front());
    end
  end

  // Monitor: scoreboard on result beats plus per-cycle ownership rules.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_in    = 0;
      m_out   = 0;
      exp_q.delete();
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (rsp_valid[r] && rsp_ready[r]) begin
          rsp_beats[r]++;
          check("sb_rsp_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_rsp_owner", r, e.id);
            check("sb_rsp_data", rsp_data, e.data);
          end
        end
      end
      if (m_owner < 0) begin
        check("idle_req_ready", req_ready, 0);
        check("idle_eng_in_valid", eng_in_valid, 0);
        check("idle_eng_out_ready", eng_out_ready, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_rsp_id", rsp_id, 0);
        if (req_valid != '0) begin
          m_owner = model_pick(req_valid, m_ptr);
          m_in    = 0;
          m_out   = 0;
          grant_log.push_back(m_owner);
          grant_cyc.push_back(cyc);
        end
      end else begin
        check("busy_rsp_id", rsp_id, m_owner);
        if (m_in < M) begin
          check("feed_eng_in_valid", eng_in_valid, req_valid[m_owner]);
          check("feed_eng_in_data", eng_in_data, req_data[m_owner]);
          check("feed_req_ready", req_ready, NR'(eng_in_ready) << m_owner);
          check("feed_rsp_valid", rsp_valid, 0);
          check("feed_eng_out_ready", eng_out_ready, 0);
          if (eng_in_valid && eng_in_ready) m_in++;
        end else begin
          check("drain_req_ready", req_ready, 0);
          check("drain_eng_in_valid", eng_in_valid, 0);
          check("drain_rsp_valid", rsp_valid, NR'(eng_out_valid) << m_owner);
          check("drain_rsp_data", rsp_data, eng_out_data);
          check("drain_eng_out_ready", eng_out_ready, rsp_ready[m_owner]);
          if (eng_out_valid && eng_out_ready) begin
            m_out++;
            if (m_out == N) begin
              m_ptr   = (m_owner + 1) % NR;
              m_owner = -1;
            end
          end
        end
      end
    end
  end

  task automatic enqueue(input int r, input int njobs);
    for (int i = 0; i < njobs * M; i++) jobq[r].push_back(W'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    bit busy;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      busy = (m_owner >= 0) || (exp_q.size() != 0);
      for (int r = 0; r < NR; r++) if (jobq[r].size() != 0) busy = 1'b1;
      t++;
    end while (busy && t < budget);
    check({name, "_completed"}, busy, 0);
  endtask

  task automatic clear_beats();
    for (int r = 0; r < NR; r++) rsp_beats[r] = 0;
  endtask

  initial begin
    int t, nf, total;
    int exp_order[5];
    reset         = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    rsp_ready     = '0;
    eng_in_ready  = 1'b0;
    eng_out_valid = 1'b0;
    eng_out_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_in_valid", eng_in_valid, 0);
    check("rst_eng_out_ready", eng_out_ready, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Lone requester 2, engine always ready.
    clear_beats();
    enqueue(2, 1);
    t = 0;
    do begin @(negedge clk); t++; end while (!req_valid[2] && t < 10);
    check("t1_req_seen", req_valid[2], 1);
    check("t1_idle_no_feed", eng_in_valid, 0);
    @(negedge clk);
    check("t1_grant_rsp_id", rsp_id, 2);
    check("t1_grant_feed", eng_in_valid, 1);
    wait_idle("t1", 100);
    check("t1_rsp_beats", rsp_beats[2], N);

    // All four requesting continuously.
    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    enqueue(0, 2);
    enqueue(1, 1);
    enqueue(2, 1);
    enqueue(3, 1);
    wait_idle("t2", 400);
`ifdef FC_ARB_PRIO0_EN
    exp_order = '{0, 0, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check("t2_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_grant_%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
    for (int i = 1; i < 5; i++)
      check($sformatf("t2_gap_%0d", i),
            (i < grant_cyc.size()) ? grant_cyc[i] - grant_cyc[i-1] : -1, M + N + 1);

    // Toggling response back-pressure.
    clear_beats();
    rsp_toggle = 1'b1;
    enqueue(1, 1);
    wait_idle("t3", 200);
    check("t3_rsp_beats", rsp_beats[1], N);
    rsp_toggle = 1'b0;

    // Priority of requester 0 with rr pointer parked at 1.
    do_reset();
    enqueue(0, 1);
    wait_idle("t4a", 100);
    grant_log.delete();
    enqueue(0, 1);
    enqueue(1, 1);
    wait_idle("t4", 200);
`ifdef FC_ARB_PRIO0_EN
    check("t4_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
`else
    check("t4_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
`endif

    // Reset in the middle of a FEED.
    do_reset();
    enqueue(1, 1);
    wait_idle("t5a", 100);
    enqueue(2, 1);
    nf = 0;
    t  = 0;
    while (nf < 2 && t < 50) begin
      @(negedge clk);
      t++;
      if (eng_in_valid && eng_in_ready) nf++;
    end
    check("t5_two_beats", nf, 2);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_req_ready", req_ready, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_eng_in_valid", eng_in_valid, 0);
    check("t5_eng_out_ready", eng_out_ready, 0);
    check("t5_rsp_data", rsp_data, 0);
    check("t5_rsp_id", rsp_id, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    grant_log.delete();
    enqueue(1, 1);
    enqueue(3, 1);
    wait_idle("t5", 200);
    check("t5_grant_after_rst", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    check("t5_grant_second", (grant_log.size() > 1) ? grant_log[1] : -1, 3);

    // Randomised traffic with stalls on every interface.
    clear_beats();
    p_gap     = 30;
    p_in_rdy  = 70;
    p_out_val = 70;
    p_rsp_rdy = 70;
    for (int i = 0; i < 12; i++) enqueue($urandom_range(NR - 1), 1);
    repeat (40) @(posedge clk);
    for (int i = 0; i < 12; i++) enqueue($urandom_range(NR - 1), 1);
    wait_idle("t6", 8000);
    total = 0;
    for (int r = 0; r < NR; r++) total += rsp_beats[r];
    check("t6_total_beats", total, 24 * N);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
